// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI frame constants and FSM state encoding
package spi_pkg;
    localparam int SPI_WIDTH = 8;
    localparam int SPI_BIT_W = $clog2(SPI_WIDTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_HIGH  = 3'd2;
    localparam logic [2:0] ST_LOW   = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;
endpackage

// File: rtl/spi_sclk_div.sv
// rtl/spi_sclk_div.sv - half-period counter, one-cycle tick every CLK_DIV cycles while enabled
module spi_sclk_div #(
    parameter int CLK_DIV = 5,
    parameter int DIV_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 byte master; SPI_MASTER_LSB_FIRST_EN selects LSB-first shifting
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 5,
    parameter int DIV_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_start,
    input  logic [SPI_WIDTH-1:0] spi_data_i,
    output logic                 spi_busy,
    output logic [SPI_WIDTH-1:0] spi_data_o,
    output logic                 spi_rxdy,
    output logic                 spi_txcomp,
    output logic                 SSEL,
    output logic                 SCK,
    output logic                 MOSI,
    input  logic                 MISO
);
    logic [2:0]           state;
    logic [SPI_BIT_W-1:0] bit_cnt;
    logic [SPI_WIDTH-1:0] shift;
    logic [SPI_WIDTH-1:0] shift_next;
    logic                 first_bit;
    logic                 next_bit;
    logic                 tick;

    // The shift happens on the rising edge together with the MISO capture, so the
    // falling edge only has to copy the already-exposed next transmit bit to MOSI.
`ifdef SPI_MASTER_LSB_FIRST_EN
    assign shift_next = {MISO, shift[SPI_WIDTH-1:1]};
    assign first_bit  = spi_data_i[0];
    assign next_bit   = shift[0];
`else
    assign shift_next = {shift[SPI_WIDTH-2:0], MISO};
    assign first_bit  = spi_data_i[SPI_WIDTH-1];
    assign next_bit   = shift[SPI_WIDTH-1];
`endif

    spi_sclk_div #(
        .CLK_DIV(CLK_DIV),
        .DIV_W  (DIV_W)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .en  (state != ST_IDLE),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        spi_rxdy   <= 1'b0;
        spi_txcomp <= 1'b0;
        if (!rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            spi_busy   <= 1'b0;
            spi_data_o <= '0;
            SSEL       <= 1'b1;
            SCK        <= 1'b0;
            MOSI       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (spi_start) begin
                        state    <= ST_SETUP;
                        shift    <= spi_data_i;
                        bit_cnt  <= SPI_BIT_W'(SPI_WIDTH - 1);
                        SSEL     <= 1'b0;
                        MOSI     <= first_bit;
                        spi_busy <= 1'b1;
                    end
                end
                ST_SETUP, ST_LOW: begin
                    if (tick) begin
                        state <= ST_HIGH;
                        SCK   <= 1'b1;
                        shift <= shift_next;
                    end
                end
                ST_HIGH: begin
                    if (tick) begin
                        SCK <= 1'b0;
                        // The eighth falling edge ends the clocking; HOLD keeps SCK low.
                        if (bit_cnt == '0) begin
                            state <= ST_HOLD;
                        end else begin
                            state   <= ST_LOW;
                            MOSI    <= next_bit;
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        state      <= ST_GAP;
                        SSEL       <= 1'b1;
                        MOSI       <= 1'b0;
                        spi_data_o <= shift;
                        spi_rxdy   <= 1'b1;
                        spi_txcomp <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        state    <= ST_IDLE;
                        spi_busy <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master with a bit-level slave model
module tb_spi_master;
    localparam int D  = 5;
    localparam int D2 = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_start = 1'b0;
    logic [7:0] spi_data_i = 8'h00;
    logic       spi_busy;
    logic [7:0] spi_data_o;
    logic       spi_rxdy, spi_txcomp, ssel, sck, mosi;
    logic       miso = 1'b0;

    logic       start2 = 1'b0;
    logic [7:0] data_i2 = 8'h00;
    logic       busy2, rxdy2, txcomp2, ssel2, sck2, mosi2;
    logic [7:0] data_o2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(D), .DIV_W(8)) u_dut (
        .clk(clk), .rst(rst), .spi_start(spi_start), .spi_data_i(spi_data_i),
        .spi_busy(spi_busy), .spi_data_o(spi_data_o), .spi_rxdy(spi_rxdy),
        .spi_txcomp(spi_txcomp), .SSEL(ssel), .SCK(sck), .MOSI(mosi), .MISO(miso)
    );

    spi_master #(.CLK_DIV(D2), .DIV_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .spi_start(start2), .spi_data_i(data_i2),
        .spi_busy(busy2), .spi_data_o(data_o2), .spi_rxdy(rxdy2),
        .spi_txcomp(txcomp2), .SSEL(ssel2), .SCK(sck2), .MOSI(mosi2), .MISO(mosi2)
    );

    // Byte bit position carried by the k-th serial bit of a frame.
    function automatic int pos(input int k);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return k;
`else
        return 7 - k;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ssel !== 1'b1) begin errors++; $display("FAIL reset_ssel got %b exp 1", ssel); end
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck got %b exp 0", sck); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b exp 0", mosi); end
        checks++; if (spi_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", spi_busy); end
        checks++; if ({spi_rxdy, spi_txcomp} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {spi_rxdy, spi_txcomp}); end
        checks++; if (spi_data_o !== 8'h00) begin errors++; $display("FAIL reset_data_o got %h exp 00", spi_data_o); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    // One frame: slave model answers rx; optional stray start at cycle inj_at after E0.
    task automatic do_frame(input logic [7:0] tx, input logic [7:0] rx, input int inj_at);
        logic [7:0] got;
        logic       prev;
        int k, rise_err, fall_err, nfall, pulses, done_at, txc_at, ssel_rise, busy_drop;
        got = 8'h00; prev = 1'b0; k = 0; rise_err = 0; fall_err = 0; nfall = 0;
        pulses = 0; done_at = -1; txc_at = -1; ssel_rise = -1; busy_drop = -1;
        @(negedge clk);
        spi_data_i = tx;
        spi_start  = 1'b1;
        @(negedge clk);
        spi_data_i = 8'($urandom);
        miso = rx[pos(0)];
        checks++; if ({ssel, spi_busy} !== 2'b01) begin errors++; $display("FAIL accept ssel/busy got %b exp 01", {ssel, spi_busy}); end
        for (int t = 0; t <= 18 * D + 2; t++) begin
            if (t > 0) @(negedge clk);
            if (t == inj_at) begin spi_start = 1'b1; spi_data_i = 8'hFF; end
            else spi_start = 1'b0;
            if (sck && !prev) begin
                if (t != D + 2 * k * D) rise_err++;
                if (k < 8) got[pos(k)] = mosi;
                k++;
            end
            if (!sck && prev) begin
                if (t != 2 * D + 2 * nfall * D) fall_err++;
                nfall++;
                if (k < 8) miso = rx[pos(k)];
            end
            if (spi_rxdy) begin pulses++; done_at = t; end
            if (spi_txcomp) txc_at = t;
            if (ssel && ssel_rise < 0) ssel_rise = t;
            if (!spi_busy && busy_drop < 0) busy_drop = t;
            prev = sck;
        end
        checks++; if (got !== tx) begin errors++; $display("FAIL mosi_byte got %h exp %h", got, tx); end
        checks++; if (spi_data_o !== rx) begin errors++; $display("FAIL rx_byte got %h exp %h", spi_data_o, rx); end
        checks++; if (k != 8 || nfall != 8) begin errors++; $display("FAIL sck_edges got %0d/%0d exp 8/8", k, nfall); end
        checks++; if (rise_err + fall_err != 0) begin errors++; $display("FAIL sck_timing got %0d bad edges exp 0", rise_err + fall_err); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL rxdy_count got %0d exp 1", pulses); end
        checks++; if (done_at != 17 * D) begin errors++; $display("FAIL rxdy_time got %0d exp %0d", done_at, 17 * D); end
        checks++; if (txc_at != done_at) begin errors++; $display("FAIL txcomp_time got %0d exp %0d", txc_at, done_at); end
        checks++; if (ssel_rise != 17 * D) begin errors++; $display("FAIL ssel_rise got %0d exp %0d", ssel_rise, 17 * D); end
        checks++; if (busy_drop != 18 * D) begin errors++; $display("FAIL busy_drop got %0d exp %0d", busy_drop, 18 * D); end
    endtask

    task automatic test_basic();
        do_frame(8'hA5, 8'h3C, -1);
        do_frame(8'hA5, 8'h3C, 30);
        do_frame(8'h01, 8'h80, -1);
    endtask

    task automatic test_random();
        do_frame(8'h00, 8'hFF, -1);
        do_frame(8'hFF, 8'h00, -1);
        for (int i = 0; i < 4; i++) do_frame(8'($urandom), 8'($urandom), -1);
    endtask

    task automatic test_back_to_back();
        int falls[$];
        int rises[$];
        logic [7:0] frames [3];
        logic prev_ssel, prev_sck;
        int nf, bitk;
        prev_ssel = 1'b1; prev_sck = 1'b0; nf = -1; bitk = 0;
        miso = 1'b0;
        for (int i = 0; i < 3; i++) frames[i] = 8'h55;
        @(negedge clk);
        spi_data_i = 8'h00;
        spi_start  = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (!ssel && prev_ssel) begin
                nf++;
                falls.push_back(t);
                bitk = 0;
                spi_data_i = (nf % 2 == 0) ? 8'hFF : 8'h00;
                if (nf >= 2) spi_start = 1'b0;
            end
            if (ssel && !prev_ssel) rises.push_back(t);
            if (sck && !prev_sck && nf >= 0 && nf < 3 && bitk < 8) begin
                frames[nf][pos(bitk)] = mosi;
                bitk++;
            end
            prev_ssel = ssel;
            prev_sck  = sck;
        end
        spi_start = 1'b0;
        checks++;
        if (falls.size() != 3 || rises.size() != 3) begin
            errors++; $display("FAIL b2b_frames got %0d/%0d exp 3/3", falls.size(), rises.size());
        end else begin
            checks++; if (falls[1] - falls[0] != 18 * D + 1) begin errors++; $display("FAIL b2b_pitch0 got %0d exp %0d", falls[1] - falls[0], 18 * D + 1); end
            checks++; if (falls[2] - falls[1] != 18 * D + 1) begin errors++; $display("FAIL b2b_pitch1 got %0d exp %0d", falls[2] - falls[1], 18 * D + 1); end
            checks++; if (falls[1] - rises[0] != D + 1) begin errors++; $display("FAIL b2b_ssel_high got %0d exp %0d", falls[1] - rises[0], D + 1); end
        end
        checks++; if (frames[0] !== 8'h00) begin errors++; $display("FAIL b2b_f0 got %h exp 00", frames[0]); end
        checks++; if (frames[1] !== 8'hFF) begin errors++; $display("FAIL b2b_f1 got %h exp ff", frames[1]); end
        checks++; if (frames[2] !== 8'h00) begin errors++; $display("FAIL b2b_f2 got %h exp 00", frames[2]); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        do_frame(8'h5A, 8'hC3, -1);
        @(negedge clk);
        spi_data_i = 8'hE7;
        spi_start  = 1'b1;
        @(negedge clk);
        spi_start = 1'b0;
        miso = 1'b1;
        repeat (39) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({ssel, sck, mosi, spi_busy} !== 4'b1000) begin errors++; $display("FAIL midrst_pins got %b exp 1000", {ssel, sck, mosi, spi_busy}); end
        checks++; if (spi_data_o !== 8'h00) begin errors++; $display("FAIL midrst_data_o got %h exp 00", spi_data_o); end
        checks++; if (spi_rxdy !== 1'b0) begin errors++; $display("FAIL midrst_rxdy got %b exp 0", spi_rxdy); end
        rst = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (spi_rxdy || spi_txcomp) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_pulse got %0d exp 0", pulses); end
        do_frame(8'($urandom), 8'($urandom), -1);
    endtask

    task automatic test_div2();
        int done_at, pulses;
        logic [7:0] tx;
        for (int i = 0; i < 2; i++) begin
            tx = (i == 0) ? 8'h81 : 8'($urandom);
            done_at = -1; pulses = 0;
            @(negedge clk);
            data_i2 = tx;
            start2  = 1'b1;
            @(negedge clk);
            start2  = 1'b0;
            data_i2 = ~tx;
            for (int t = 0; t < 50; t++) begin
                if (t > 0) @(negedge clk);
                if (rxdy2) begin pulses++; done_at = t; end
            end
            checks++; if (data_o2 !== tx) begin errors++; $display("FAIL div2_loop got %h exp %h", data_o2, tx); end
            checks++; if (done_at != 17 * D2 || pulses != 1) begin errors++; $display("FAIL div2_done got %0d x%0d exp %0d x1", done_at, pulses, 17 * D2); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_div2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
